// File: rtl/pipe_pkg.sv
// Shared pipeline types: stage modes, skid FSM states, perf width
// and the control-field layout carried between ID and EX.
package pipe_pkg;

  localparam int MODE_REG   = 0;
  localparam int MODE_SKID  = 1;
  localparam int PERF_CNT_W = 32;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_FULL,
    ST_SKID
  } state_t;

  typedef struct packed {
    logic       we;
    logic       wr;
    logic [3:0] alu_op;
    logic       dram_we;
    logic [8:0] rsvd;
  } id_ex_ctrl_t;

  function automatic logic [PERF_CNT_W-1:0] sat_inc(
    input logic [PERF_CNT_W-1:0] v,
    input logic                  en
  );
    logic [PERF_CNT_W-1:0] r;
    r = v;
    if (en && (v != '1)) r = v + 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating event counter for the stage perf outputs.
// Ports: clk, rst_n, inc_i (count enable), cnt_o (value, sticks at max).
module pipe_sat_counter
  import pipe_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inc_i,
  output logic [PERF_CNT_W-1:0] cnt_o
);

  logic [PERF_CNT_W-1:0] cnt_q;
  logic [PERF_CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = sat_inc(cnt_q, inc_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline-stage register; MODE 0 plain, MODE 1 skid.
// Ports: clk, rst_n, flush, in_valid/in_ready/in_ctrl/in_data upstream,
// out_valid/out_ready/out_ctrl/out_data downstream.
// Optional PIPE_STAGE_PERF_EN adds perf_stall/perf_bubble/perf_flush.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16,
  parameter int MODE   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0] perf_stall,
  output logic [PERF_CNT_W-1:0] perf_bubble,
  output logic [PERF_CNT_W-1:0] perf_flush
`endif
);

  logic              vld_q, vld_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;

  if (MODE == MODE_SKID) begin : g_skid
    state_t            state_q, state_d;
    logic              rdy_q;
    logic [CTRL_W-1:0] sk_ctrl_q, sk_ctrl_d;
    logic [DATA_W-1:0] sk_data_q, sk_data_d;

    always_comb begin
      state_d   = state_q;
      ctrl_d    = ctrl_q;
      data_d    = data_q;
      sk_ctrl_d = sk_ctrl_q;
      sk_data_d = sk_data_q;
      if (flush) begin
        state_d = ST_EMPTY;
        ctrl_d  = '0;
      end else begin
        unique case (state_q)
          ST_EMPTY: begin
            if (in_valid) begin
              ctrl_d  = in_ctrl;
              data_d  = in_data;
              state_d = ST_FULL;
            end
          end
          ST_FULL: begin
            if (out_ready && in_valid) begin
              ctrl_d = in_ctrl;
              data_d = in_data;
            end else if (out_ready) begin
              state_d = ST_EMPTY;
            end else if (in_valid) begin
              sk_ctrl_d = in_ctrl;
              sk_data_d = in_data;
              state_d   = ST_SKID;
            end
          end
          ST_SKID: begin
            if (out_ready) begin
              ctrl_d  = sk_ctrl_q;
              data_d  = sk_data_q;
              state_d = ST_FULL;
            end
          end
          default: state_d = ST_EMPTY;
        endcase
      end
      vld_d = (state_d != ST_EMPTY);
    end

    // ready is taken from the next state so the upstream sees a flop
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q   <= ST_EMPTY;
        rdy_q     <= 1'b1;
        sk_ctrl_q <= '0;
        sk_data_q <= '0;
        vld_q     <= 1'b0;
        ctrl_q    <= '0;
        data_q    <= '0;
      end else begin
        state_q   <= state_d;
        rdy_q     <= (state_d != ST_SKID);
        sk_ctrl_q <= sk_ctrl_d;
        sk_data_q <= sk_data_d;
        vld_q     <= vld_d;
        ctrl_q    <= ctrl_d;
        data_q    <= data_d;
      end
    end

    assign in_ready = rdy_q;
  end else begin : g_reg
    logic rdy;

    assign rdy = !vld_q || out_ready;

    always_comb begin
      vld_d  = vld_q;
      ctrl_d = ctrl_q;
      data_d = data_q;
      if (flush) begin
        vld_d  = 1'b0;
        ctrl_d = '0;
      end else if (in_valid && rdy) begin
        vld_d  = 1'b1;
        ctrl_d = in_ctrl;
        data_d = in_data;
      end else if (vld_q && out_ready) begin
        vld_d = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q  <= 1'b0;
        ctrl_q <= '0;
        data_q <= '0;
      end else begin
        vld_q  <= vld_d;
        ctrl_q <= ctrl_d;
        data_q <= data_d;
      end
    end

    assign in_ready = rdy;
  end

  assign out_valid = vld_q;
  assign out_ctrl  = ctrl_q;
  assign out_data  = data_q;

`ifdef PIPE_STAGE_PERF_EN
  pipe_sat_counter u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (vld_q && !out_ready),
    .cnt_o (perf_stall)
  );

  pipe_sat_counter u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (!vld_q),
    .cnt_o (perf_bubble)
  );

  pipe_sat_counter u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (flush),
    .cnt_o (perf_flush)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: one MODE 1 and one MODE 0
// instance share stimulus; each phase checks the relevant instance.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [15:0] in_ctrl;
  logic [31:0] in_data;
  logic        out_ready;

  logic        v1, r1, v0, r0;
  logic [15:0] c1, c0;
  logic [31:0] d1, d0;

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] ps1, pb1, pf1;
  logic [31:0] ps0, pb0, pf0;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .MODE(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (r1),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (v1),
    .out_ready (out_ready),
    .out_ctrl  (c1),
    .out_data  (d1)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .perf_stall  (ps1),
    .perf_bubble (pb1),
    .perf_flush  (pf1)
`endif
  );

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .MODE(0)) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (r0),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (v0),
    .out_ready (out_ready),
    .out_ctrl  (c0),
    .out_data  (d0)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .perf_stall  (ps0),
    .perf_bubble (pb0),
    .perf_flush  (pf0)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] c,
                       input logic [31:0] d);
    in_valid = v;
    in_ctrl  = c;
    in_data  = d;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 16'h0, 32'h0);
    repeat (3) tick();
    chk("rst_v1", 32'(v1), 32'd0);
    chk("rst_d1", d1, 32'd0);
    chk("rst_c1", 32'(c1), 32'd0);
    chk("rst_r1", 32'(r1), 32'd1);
    chk("rst_v0", 32'(v0), 32'd0);
    chk("rst_d0", d0, 32'd0);
    rst_n = 1'b1;

    // streaming 1..8, one beat per cycle
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 16'h0, 32'(i));
      tick();
      chk("str_d1", d1, 32'(i));
      chk("str_v1", 32'(v1), 32'd1);
      chk("str_r1", 32'(r1), 32'd1);
    end
    drive(1'b0, 16'h0, 32'h0);
    tick();
    chk("str_end_v1", 32'(v1), 32'd0);

    // backpressure into skid
    out_ready = 1'b0;
    drive(1'b1, 16'h0, 32'hA);
    tick();
    chk("bp_a_d1", d1, 32'hA);
    chk("bp_a_r1", 32'(r1), 32'd1);
    drive(1'b1, 16'h0, 32'hB);
    tick();
    chk("bp_hold_d1", d1, 32'hA);
    chk("bp_skid_r1", 32'(r1), 32'd0);
    drive(1'b1, 16'h0, 32'hC);
    tick();
    chk("bp_c_ign_d1", d1, 32'hA);
    chk("bp_c_ign_r1", 32'(r1), 32'd0);
    out_ready = 1'b1;
    tick();
    chk("bp_b_d1", d1, 32'hB);
    chk("bp_b_r1", 32'(r1), 32'd1);
    tick();
    chk("bp_c_d1", d1, 32'hC);
    drive(1'b0, 16'h0, 32'h0);
    tick();
    chk("bp_end_v1", 32'(v1), 32'd0);

    // flush while in skid
    out_ready = 1'b0;
    drive(1'b1, 16'h00FF, 32'h11);
    tick();
    chk("fl_c1", 32'(c1), 32'h00FF);
    drive(1'b1, 16'h0F0F, 32'h22);
    tick();
    chk("fl_skid_r1", 32'(r1), 32'd0);
    drive(1'b0, 16'h0, 32'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_v1", 32'(v1), 32'd0);
    chk("fl_ctrl1", 32'(c1), 32'd0);
    chk("fl_data1", d1, 32'h11);
    chk("fl_r1", 32'(r1), 32'd1);
    out_ready = 1'b1;
    tick();
    chk("fl_nob_v1", 32'(v1), 32'd0);
    tick();
    chk("fl_nob_d1", d1, 32'h11);

    // flush drops a same-cycle beat
    drive(1'b1, 16'h1, 32'hDEAD);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 16'h0, 32'h0);
    chk("fv_v1", 32'(v1), 32'd0);
    chk("fv_d1", d1, 32'h11);
    chk("fv_v0", 32'(v0), 32'd0);
    tick();
    chk("fv_v1_after", 32'(v1), 32'd0);

    // MODE 0 stall then full-rate drain
    out_ready = 1'b0;
    drive(1'b1, 16'h0, 32'h100);
    tick();
    chk("m0_v0", 32'(v0), 32'd1);
    chk("m0_d0", d0, 32'h100);
    drive(1'b1, 16'h0, 32'h101);
    #1;
    chk("m0_stall_r0", 32'(r0), 32'd0);
    tick();
    chk("m0_hold_d0", d0, 32'h100);
    out_ready = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      drive(1'b1, 16'h0, 32'h100 + 32'(j));
      #1;
      chk("m0_run_r0", 32'(r0), 32'd1);
      tick();
      chk("m0_run_d0", d0, 32'h100 + 32'(j));
      chk("m0_run_v0", 32'(v0), 32'd1);
    end
    drive(1'b0, 16'h0, 32'h0);
    tick();
    chk("m0_end_v0", 32'(v0), 32'd0);

    // reset asserted mid-stall
    out_ready = 1'b0;
    drive(1'b1, 16'h0, 32'h31);
    tick();
    drive(1'b1, 16'h0, 32'h32);
    tick();
    chk("mr_skid_r1", 32'(r1), 32'd0);
    drive(1'b0, 16'h0, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("mr_v1", 32'(v1), 32'd0);
    chk("mr_r1", 32'(r1), 32'd1);
    chk("mr_d1", d1, 32'd0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("mr_after_v1", 32'(v1), 32'd0);

`ifdef PIPE_STAGE_PERF_EN
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, 16'h0, 32'h0);
    repeat (3) tick();
    drive(1'b1, 16'h0, 32'h77);
    tick();
    drive(1'b0, 16'h0, 32'h0);
    repeat (5) tick();
    out_ready = 1'b1;
    flush = 1'b1;
    repeat (2) tick();
    flush = 1'b0;
    chk("pf_stall", ps1, 32'd5);
    chk("pf_flush", pf1, 32'd2);
    chk("pf_bubble", pb1, 32'd5);
    force dut1.u_stall_cnt.cnt_q = 32'hFFFF_FFFD;
    #1;
    release dut1.u_stall_cnt.cnt_q;
    out_ready = 1'b0;
    drive(1'b1, 16'h0, 32'h78);
    tick();
    drive(1'b0, 16'h0, 32'h0);
    repeat (4) tick();
    chk("pf_sat", ps1, 32'hFFFF_FFFF);
    out_ready = 1'b1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
